mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer and arbiter for the shared memory address path. Accepts requests from the instruction-fetch unit and the load/store unit and grants one at a time using two-way round-robin. For the granted request it loads the memory access register (MAR), waits out the fixed memory latency, and returns read data or completes the write with a one-cycle done pulse. It sits between the two requesters and the MAR/memory pair.

## Interface
Parameters:
- ADDR_W, 16, address width (matches MAR)
- DATA_W, 16, memory data width
- MEM_LAT, 2, cycles from MAR update to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_done  out  1  one-cycle pulse: fetch complete, rdata valid
- ls_req  in  1  load/store request; held high until ls_done
- ls_we  in  1  1 = store, 0 = load; stable while ls_req is high
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_done  out  1  one-cycle pulse: load/store complete
- rdata  out  DATA_W  captured read data; valid during the done pulse, held until the next capture
- mar_load  out  1  MAR update strobe
- mar_addr  out  ADDR_W  address presented to the MAR input
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
FSM states and transitions:
- IDLE: arbitrate. If any req is high, latch winner, addr, we, wdata, then go to ADDR.
- ADDR (1 cycle): mar_load=1, mar_addr=latched addr. Next state is WAIT; counter is loaded with MEM_LAT-1.
- WAIT (MEM_LAT cycles): mem_we=latched we (stores only), mem_wdata=latched wdata. Counter decrements. On the edge leaving the final WAIT cycle (cnt==0), rdata<=mem_rdata (loads/fetches only; stores leave rdata unchanged). Next state is RESP.
- RESP (1 cycle): the grantee's done=1. Arbitrate with the current grantee masked, since its req is still high this cycle. If the other req is high, latch it and go to ADDR; otherwise go to IDLE.

Arbitration rules:
- Round-robin on a `last` bit. When both requests are high, the requester not served last wins. `last` updates on every grant.
- Reset sets last=LS, so fetch wins the first tie.

Request handling:
- A req deasserted mid-transaction does not abort it; done still pulses. A req that is still high after done is not re-granted in the same RESP cycle.
- Inputs are sampled only at grant. Changes to addr, we or wdata after grant are ignored.

Output rules:
- mar_load, if_done, ls_done, mem_we and busy are decoded from state. There is no combinational path from req to any output.
- Reset values of all outputs: 0. rdata=0. State=IDLE, cnt=0, last=LS.
- Reset asserted mid-transaction returns to IDLE immediately. No done pulse is issued and mem_we drops asynchronously.

## Timing
- Request high in IDLE cycle 0 gives: ADDR in cycle 1, WAIT in cycles 2..MEM_LAT+1, done in cycle MEM_LAT+2. The default latency is 4 cycles.
- The MAR output holds the new address from cycle 2 onward.
- Back-to-back alternating grants: the next ADDR follows RESP directly with no IDLE cycle. Throughput is one access per MEM_LAT+2 cycles.
- Same requester issuing back-to-back: it drops req after done, so at least one IDLE cycle separates its transactions.

## Structure
- Package mem_access_pkg: state enum {IDLE, ADDR, WAIT, RESP}, requester index constants REQ_IF=0 and REQ_LS=1, and the default MEM_LAT.
- Sub-module rr_arb2: two-input round-robin arbiter with mask input, `last` register and one-hot grant output. The FSM, counter and latches stay in mem_access_ctrl.
- The MAR is instantiated alongside this block, not inside it.

## Test plan
- Single fetch, if_addr=16'h0040, mem_rdata=16'hBEEF in the final WAIT cycle: mar_load in cycle 1, if_done in cycle 4, rdata=16'hBEEF, ls_done stays 0.
- Store, ls_we=1, ls_addr=16'h1234, ls_wdata=16'h00FF: mem_we=1 in cycles 2–3 with mem_wdata=16'h00FF, ls_done in cycle 4, rdata unchanged.
- Both requests high at cycle 0 after reset: fetch granted first, if_done in cycle 4. LS goes to ADDR in cycle 5 and ls_done arrives in cycle 8, with no IDLE cycle between.
- Both requests held continuously: grants alternate IF, LS, IF, LS, with done every 4 cycles.
- Reset pulsed during WAIT of a fetch: all outputs 0 immediately, no if_done. After release, a held if_req restarts with done 4 cycles later.
- MEM_LAT=1 build: done in cycle 3. if_addr changed after grant: mar_addr keeps the original value.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared types and constants for the memory access sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int REQ_IF      = 0;
    localparam int REQ_LS      = 1;
    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin arbiter with request mask and one-hot grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_access_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic       last_q;
    logic [1:0] w_req;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_req = req_i & ~mask_i;
        gnt_o = w_req;
        if (w_req == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update_i && (|gnt_o)) begin
            last_q <= gnt_o[REQ_LS];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : Arbitrates fetch and load/store requests onto the MAR/memory path.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_load,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              who_q, who_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        w_mask;
    logic              w_update;
    logic [1:0]        w_gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({ls_req, if_req}),
        .mask_i   (w_mask),
        .update_i (w_update),
        .gnt_o    (w_gnt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        who_d    = who_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        w_mask   = 2'b00;
        w_update = 1'b0;

        case (state_q)
            IDLE: begin
                w_update = 1'b1;
            end
            ADDR: begin
                cnt_d   = C_CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Grantee's req is still high here; keep it from winning again.
                w_mask[REQ_IF] = ~who_q;
                w_mask[REQ_LS] = who_q;
                w_update       = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_update && (|w_gnt)) begin
            who_d   = w_gnt[REQ_LS];
            addr_d  = w_gnt[REQ_LS] ? ls_addr : if_addr;
            we_d    = w_gnt[REQ_LS] & ls_we;
            wdata_d = ls_wdata;
            state_d = ADDR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            who_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            who_q   <= who_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mar_load  = (state_q == ADDR);
    assign mar_addr  = addr_q;
    assign mem_we    = (state_q == WAIT) && we_q;
    assign mem_wdata = (state_q == WAIT) ? wdata_q : '0;
    assign if_done   = (state_q == RESP) && !who_q;
    assign ls_done   = (state_q == RESP) && who_q;
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Self-checking bench: transaction-level model plus directed checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr, ls_wdata, mem_rdata;

    logic        if_done, ls_done, mar_load, mem_we, busy;
    logic [15:0] rdata, mar_addr, mem_wdata;

    logic        if_done2, ls_done2, mar_load2, mem_we2, busy2;
    logic [15:0] rdata2, mar_addr2, mem_wdata2;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .rdata(rdata), .mar_load(mar_load), .mar_addr(mar_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done2),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done2), .rdata(rdata2), .mar_load(mar_load2), .mar_addr(mar_addr2),
        .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transaction is an age count from its ADDR cycle: age 0 = ADDR,
    // 1..LAT = WAIT, LAT+1 = done.
    bit          m_have, m_who, m_we, m_last;
    int          m_age;
    logic [15:0] m_addr, m_wdata, m_rdata;
    bit          m_if_done, m_ls_done;

    task automatic m_grant(input bit a_if, input bit a_ls);
        bit win;
        if (a_if || a_ls) begin
            win      = (a_if && a_ls) ? !m_last : a_ls;
            m_last   = win;
            m_have   = 1'b1;
            m_age    = 0;
            m_who    = win;
            m_addr   = win ? ls_addr : if_addr;
            m_we     = win && ls_we;
            m_wdata  = ls_wdata;
        end
    endtask

    always begin
        bit e_addr, e_wait, e_done;
        @(negedge clk);
        if (rst) begin
            m_have = 0; m_age = 0; m_last = 1; m_rdata = '0;
            m_if_done = 0; m_ls_done = 0;
            chk("rst_busy",      32'(busy),      0);
            chk("rst_mar_load",  32'(mar_load),  0);
            chk("rst_if_done",   32'(if_done),   0);
            chk("rst_ls_done",   32'(ls_done),   0);
            chk("rst_mem_we",    32'(mem_we),    0);
            chk("rst_rdata",     32'(rdata),     0);
            chk("rst_mar_addr",  32'(mar_addr),  0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
        end else begin
            e_addr    = m_have && (m_age == 0);
            e_wait    = m_have && (m_age >= 1) && (m_age <= LAT);
            e_done    = m_have && (m_age == LAT + 1);
            m_if_done = e_done && !m_who;
            m_ls_done = e_done && m_who;
            chk("busy",     32'(busy),     32'(m_have));
            chk("mar_load", 32'(mar_load), 32'(e_addr));
            chk("if_done",  32'(if_done),  32'(m_if_done));
            chk("ls_done",  32'(ls_done),  32'(m_ls_done));
            chk("mem_we",   32'(mem_we),   32'(e_wait && m_we));
            chk("rdata",    32'(rdata),    32'(m_rdata));
            if (e_addr)          chk("mar_addr",  32'(mar_addr),  32'(m_addr));
            if (e_wait && m_we)  chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            // advance to the next cycle using the inputs visible now
            if (m_have) begin
                if (m_age == LAT && !m_we) m_rdata = mem_rdata;
                if (e_done) begin
                    m_have = 0;
                    m_grant(if_req && m_who, ls_req && !m_who);
                end else begin
                    m_age++;
                end
            end else begin
                m_grant(if_req, ls_req);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_busy",  32'(busy),  0);
        chk("lit_rst_rdata", 32'(rdata), 0);
        rst = 1'b0;

        // single fetch
        next_cyc();
        if_req = 1; if_addr = 16'h0040; mem_rdata = 16'hBEEF;
        adv(2);
        chk("lit_f_mar_load", 32'(mar_load), 1);
        chk("lit_f_mar_addr", 32'(mar_addr), 32'h0040);
        adv(3);
        chk("lit_f_if_done",  32'(if_done), 1);
        chk("lit_f_rdata",    32'(rdata),   32'hBEEF);
        chk("lit_f_ls_done",  32'(ls_done), 0);
        next_cyc();
        if_req = 0;

        // single store
        next_cyc();
        ls_req = 1; ls_we = 1; ls_addr = 16'h1234; ls_wdata = 16'h00FF;
        adv(3);
        chk("lit_s_mem_we_c2",    32'(mem_we),    1);
        chk("lit_s_mem_wdata_c2", 32'(mem_wdata), 32'h00FF);
        adv(1);
        chk("lit_s_mem_we_c3",    32'(mem_we),    1);
        adv(1);
        chk("lit_s_ls_done", 32'(ls_done), 1);
        chk("lit_s_rdata",   32'(rdata),   32'hBEEF);
        next_cyc();
        ls_req = 0; ls_we = 0;

        // simultaneous requests after reset: fetch first, then LS back-to-back
        next_cyc();
        do_reset();
        if_req = 1; if_addr = 16'h0100; ls_req = 1; ls_addr = 16'h0200;
        adv(5);
        chk("lit_b_if_done", 32'(if_done), 1);
        chk("lit_b_ls_done", 32'(ls_done), 0);
        next_cyc();
        if_req = 0;
        adv(1);
        chk("lit_b_ls_addr_cyc", 32'(mar_load), 1);
        chk("lit_b_ls_mar_addr", 32'(mar_addr), 32'h0200);
        adv(3);
        chk("lit_b_ls_done8", 32'(ls_done), 1);
        next_cyc();
        ls_req = 0;

        // reset in the middle of a fetch's WAIT phase
        next_cyc();
        if_req = 1; if_addr = 16'h0ABC;
        adv(3);
        chk("lit_r_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("lit_r_busy",     32'(busy),     0);
        chk("lit_r_mem_we",   32'(mem_we),   0);
        chk("lit_r_if_done",  32'(if_done),  0);
        chk("lit_r_rdata",    32'(rdata),    0);
        @(posedge clk);
        next_cyc();
        rst = 1'b0;
        adv(5);
        chk("lit_r_restart_done", 32'(if_done), 1);
        next_cyc();
        if_req = 0;

        // MEM_LAT=1 build; address change after grant must be ignored
        next_cyc();
        do_reset();
        if_req = 1; if_addr = 16'h0777; mem_rdata = 16'h5A5A;
        next_cyc();
        if_addr = 16'h1111;
        adv(1);
        chk("lit_l1_mar_load", 32'(mar_load2), 1);
        chk("lit_l1_mar_addr", 32'(mar_addr2), 32'h0777);
        adv(2);
        chk("lit_l1_if_done",  32'(if_done2), 1);
        chk("lit_l1_rdata",    32'(rdata2),   32'h5A5A);
        adv(1);
        next_cyc();
        if_req = 0;

        // randomized traffic with occasional reset pulses
        next_cyc();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            next_cyc();
            mem_rdata = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            if (m_if_done) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 16'($urandom);
            end else if (if_req && $urandom_range(0, 7) == 0) if_addr = 16'($urandom);
            if (m_ls_done) begin
                ls_req = 0;
            end else if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1; ls_we = 1'($urandom_range(0, 1));
                ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
            end else if (ls_req && $urandom_range(0, 7) == 0) begin
                ls_we = 1'($urandom_range(0, 1)); ls_wdata = 16'($urandom);
            end
        end
        next_cyc();
        rst = 0; if_req = 0; ls_req = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_access_ctrl
`default_nettype wire
